uart_rx: RTL and testbench

- Asynchronous serial receiver, the receive-side counterpart of the team's UART transmitter. Same frame format: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Oversamples RX_IN by a runtime prescale and takes a 3-sample majority vote at mid-bit.
- Delivers the parallel word with a one-cycle valid pulse, plus parity and framing error flags, to the host-side logic.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 54 +++++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
package uart_rx_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   // Sample points sit at P/2 - SAMPLE_PRE, P/2 and P/2 + SAMPLE_POST.
   localparam int unsigned SAMPLE_PRE     = 1;
   localparam int unsigned SAMPLE_POST    = 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the receiver: edge/bit counters and the 3-sample mid-bit majority voter.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned PRESCALE_W = 6,
   localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 3)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  rx_s,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  sample_bit_c,
   output logic                  sample_done_c,
   output logic                  bit_end_c
);

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] mid;
   logic [PRESCALE_W-1:0] pt_early;
   logic [PRESCALE_W-1:0] pt_late;
   logic [PRESCALE_W-1:0] pt_last;
   logic [1:0]            smp;

   assign mid      = prescale >> 1;
   assign pt_early = mid - PRESCALE_W'(SAMPLE_PRE);
   assign pt_late  = mid + PRESCALE_W'(SAMPLE_POST);
   assign pt_last  = prescale - PRESCALE_W'(1);

   // The third sample is taken live at the resolve point.
   assign sample_done_c = (edge_cnt == pt_late);
   assign sample_bit_c  = majority3(smp[0], smp[1], rx_s);
   assign bit_end_c     = (edge_cnt == pt_last);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
         smp      <= 2'b11;
      end else begin
         if (bit_end_c) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
         end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
         end
         if (edge_cnt == pt_early) smp[0] <= rx_s;
         if (edge_cnt == mid)      smp[1] <= rx_s;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity check and registered host outputs.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR,
   output logic                  RX_BUSY
);

   localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 3);

   rx_state_e             state;
   rx_state_e             next_state;
   logic                  rx_meta;
   logic                  rx_s;
   logic [PRESCALE_W-1:0] prescale_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_err_q;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  sample_bit_c;
   logic                  sample_done_c;
   logic                  bit_end_c;
   logic                  start_det_c;
   logic                  shift_c;
   logic                  par_chk_c;
   logic                  frame_done_c;

   uart_rx_sampler #(
      .DATA_WIDTH (DATA_WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .clk           (CLK),
      .rst           (RST),
      .clear         (next_state == IDLE),
      .rx_s          (rx_s),
      .prescale      (prescale_q),
      .bit_cnt       (bit_cnt),
      .sample_bit_c  (sample_bit_c),
      .sample_done_c (sample_done_c),
      .bit_end_c     (bit_end_c)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (!rx_s) next_state = START;
         START: begin
            if (sample_done_c && sample_bit_c) next_state = IDLE;
            else if (bit_end_c)                next_state = DATA;
         end
         DATA: begin
            if (bit_end_c && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
               next_state = par_en_q ? PARITY : STOP;
         end
         PARITY:  if (bit_end_c) next_state = STOP;
         // Leave at the resolve point so a following start edge is caught early.
         STOP:    if (sample_done_c) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      start_det_c  = 1'b0;
      shift_c      = 1'b0;
      par_chk_c    = 1'b0;
      frame_done_c = 1'b0;
      unique case (state)
         IDLE:    start_det_c  = !rx_s;
         DATA:    shift_c      = sample_done_c;
         PARITY:  par_chk_c    = sample_done_c;
         STOP:    frame_done_c = sample_done_c;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         prescale_q <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         shreg      <= '0;
         par_err_q  <= 1'b0;
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         RX_BUSY    <= 1'b0;
      end else begin
         rx_meta    <= RX_IN;
         rx_s       <= rx_meta;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         RX_BUSY    <= (next_state != IDLE);
         if (start_det_c) begin
            prescale_q <= PRESCALE;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            par_err_q  <= 1'b0;
         end
         if (shift_c) shreg <= {sample_bit_c, shreg[DATA_WIDTH-1:1]};
         if (par_chk_c) par_err_q <= (sample_bit_c != ((^shreg) ^ par_typ_q));
         // Errored frames leave P_DATA untouched and only raise flags.
         if (frame_done_c) begin
            if (!par_err_q && sample_bit_c) begin
               P_DATA     <= shreg;
               DATA_VALID <= 1'b1;
            end else begin
               PAR_ERR <= par_err_q;
               STP_ERR <= !sample_bit_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as they are sent and checked when outputs pulse.
module tb_uart_rx;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic          RX_IN;
   logic [PW-1:0] PRESCALE;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic [DW-1:0] P_DATA;
   logic          DATA_VALID;
   logic          PAR_ERR;
   logic          STP_ERR;
   logic          RX_BUSY;

   uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PRESCALE   (PRESCALE),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR),
      .RX_BUSY    (RX_BUSY)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic          dv;
      logic          pe;
      logic          se;
      int            at;
   } exp_t;

   exp_t          sb[$];
   exp_t          got;
   int            tests_run = 0;
   int            tests_failed = 0;
   logic [DW-1:0] last_good = '0;

   // Any output pulse must match the oldest queued frame, field by field and cycle-exact.
   always @(negedge CLK) begin
      if (DATA_VALID || PAR_ERR || STP_ERR) begin
         if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b at cycle %0d, expected none",
                     DATA_VALID, PAR_ERR, STP_ERR, cyc);
         end else begin
            got = sb.pop_front();
            tests_run += 5;
            if (cyc !== got.at) begin
               tests_failed++;
               $display("FAIL out_cycle: got %0d, expected %0d", cyc, got.at);
            end
            if (DATA_VALID !== got.dv) begin
               tests_failed++;
               $display("FAIL data_valid: got %b, expected %b", DATA_VALID, got.dv);
            end
            if (PAR_ERR !== got.pe) begin
               tests_failed++;
               $display("FAIL par_err: got %b, expected %b", PAR_ERR, got.pe);
            end
            if (STP_ERR !== got.se) begin
               tests_failed++;
               $display("FAIL stp_err: got %b, expected %b", STP_ERR, got.se);
            end
            if (P_DATA !== got.data) begin
               tests_failed++;
               $display("FAIL p_data: got %h, expected %h", P_DATA, got.data);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1 RX_IN = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen, input bit ptyp,
                             input bit pflip, input bit stopv, input bit glitch);
      int   n;
      logic pb;
      logic bv;
      exp_t x;
      PRESCALE = PW'(p);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      pb       = (^d) ^ ptyp ^ pflip;
      n        = DW + 1 + (pen ? 1 : 0);
      x.pe     = pen && pflip;
      x.se     = !stopv;
      x.dv     = !(x.pe || x.se);
      if (x.dv) last_good = d;
      x.data   = last_good;
      for (int b = 0; b <= n; b++) begin
         if (b == 0)                 bv = 1'b0;
         else if (b <= DW)           bv = d[b-1];
         else if (b == n)            bv = stopv;
         else                        bv = pb;
         for (int k = 0; k < p; k++) begin
            @(posedge CLK);
            #1;
            if (b == 0 && k == 0) begin
               // Two synchronizer stages put t0 two cycles after the line falls.
               x.at = cyc + 2 + n * p + p / 2 + 2;
               sb.push_back(x);
            end
            RX_IN = (glitch && k == p / 2) ? ~bv : bv;
         end
      end
   endtask

   task automatic check_drained(input string name);
      tests_run += 2;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL %s_pending: %0d frames still outstanding, expected 0", name, sb.size());
         sb.delete();
      end
      if (RX_BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_busy: got %b, expected 0", name, RX_BUSY);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; RX_IN = 1'b1; PRESCALE = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      tests_run += 5;
      if (P_DATA !== '0)       begin tests_failed++; $display("FAIL rst_p_data: got %h, expected 00", P_DATA); end
      if (DATA_VALID !== 1'b0) begin tests_failed++; $display("FAIL rst_dv: got %b, expected 0", DATA_VALID); end
      if (PAR_ERR !== 1'b0)    begin tests_failed++; $display("FAIL rst_pe: got %b, expected 0", PAR_ERR); end
      if (STP_ERR !== 1'b0)    begin tests_failed++; $display("FAIL rst_se: got %b, expected 0", STP_ERR); end
      if (RX_BUSY !== 1'b0)    begin tests_failed++; $display("FAIL rst_busy: got %b, expected 0", RX_BUSY); end
      last_good = '0;
      idle(10);
   endtask

   task automatic test_parity_ok();
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(24);
      check_drained("parity_ok");
   endtask

   task automatic test_parity_err();
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(24);
      check_drained("parity_err");
   endtask

   task automatic test_stop_err();
      send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(64);
      check_drained("stop_err");
   endtask

   task automatic test_start_glitch();
      PRESCALE = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;
      repeat (3) begin
         @(posedge CLK);
         #1 RX_IN = 1'b0;
      end
      @(posedge CLK);
      #1 RX_IN = 1'b1;
      @(negedge CLK);
      tests_run++;
      if (RX_BUSY !== 1'b1) begin
         tests_failed++;
         $display("FAIL glitch_busy_high: got %b, expected 1", RX_BUSY);
      end
      repeat (6) @(negedge CLK);
      tests_run++;
      if (RX_BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL glitch_busy_low: got %b, expected 0", RX_BUSY);
      end
      idle(16);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(24);
      check_drained("glitch");
   endtask

   task automatic test_back_to_back();
      send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(96);
      check_drained("back_to_back");
   endtask

   task automatic test_reset_mid();
      PRESCALE = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;
      repeat (8) begin
         @(posedge CLK);
         #1 RX_IN = 1'b0;
      end
      repeat (20) begin
         @(posedge CLK);
         #1 RX_IN = 1'b1;
      end
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      tests_run += 5;
      if (P_DATA !== '0)       begin tests_failed++; $display("FAIL mid_rst_p_data: got %h, expected 00", P_DATA); end
      if (DATA_VALID !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_dv: got %b, expected 0", DATA_VALID); end
      if (PAR_ERR !== 1'b0)    begin tests_failed++; $display("FAIL mid_rst_pe: got %b, expected 0", PAR_ERR); end
      if (STP_ERR !== 1'b0)    begin tests_failed++; $display("FAIL mid_rst_se: got %b, expected 0", STP_ERR); end
      if (RX_BUSY !== 1'b0)    begin tests_failed++; $display("FAIL mid_rst_busy: got %b, expected 0", RX_BUSY); end
      last_good = '0;
      idle(100);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(24);
      check_drained("reset_mid");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_parity_ok();
      test_parity_err();
      test_stop_err();
      test_start_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
